// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for mem_ctrl: access sizes, FSM states, zero constants and the IO region selector.
package mem_ctrl_pkg;

  localparam int AddrW = 32;

  typedef enum logic [1:0] {
    MEM_NOP  = 2'd0,
    MEM_BYTE = 2'd1,
    MEM_HALF = 2'd2,
    MEM_WORD = 2'd3
  } mem_sel_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [31:0] ZeroWord    = 32'h0;
  localparam logic [7:0]  ZeroByte    = 8'h0;
  localparam logic [1:0]  IoRegionSel = 2'b11;

  function automatic logic [2:0] sel_bytes(input logic [1:0] sel);
    case (mem_sel_e'(sel))
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      MEM_WORD: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request bundle (IF + MEM stages) and byte-wide RAM/IO bus bundle for mem_ctrl.
interface mem_ctrl_if import mem_ctrl_pkg::*; #(parameter int ADDR_W = AddrW);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    input  if_data, if_done, mem_rdata, mem_done
  );
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    output if_data, if_done, mem_rdata, mem_done
  );
endinterface

interface mem_ctrl_ram_if import mem_ctrl_pkg::*; #(parameter int ADDR_W = AddrW);
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              io_full;

  modport master (output ram_a, ram_wr, ram_dout, input ram_din, io_full);
  modport slave  (input ram_a, ram_wr, ram_dout, output ram_din, io_full);
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF/MEM requests onto a byte RAM bus; read done n+2, write done n+1 cycles after accept.
// Stores to the IO region stall on io_full only when MEM_CTRL_IO_BACKPRESSURE_EN is defined.
module mem_ctrl import mem_ctrl_pkg::*; #(
  parameter int ADDR_W     = AddrW,
  parameter int IO_BITS_HI = 17
) (
  input  logic           clk,
  input  logic           rst,
  mem_ctrl_if.slave      req,
  mem_ctrl_ram_if.master ram
);

`ifdef MEM_CTRL_IO_BACKPRESSURE_EN
  localparam bit IoBpEn = 1'b1;
`else
  localparam bit IoBpEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lane_q, lane_d;
  logic              src_if_q, src_if_d;

  logic [ADDR_W-1:0] cur_a;
  logic              io_hit;
  logic              wr_stall;
  logic [7:0]        wr_byte;

  assign cur_a    = addr_q + ADDR_W'(cnt_q);
  assign io_hit   = (cur_a[IO_BITS_HI -: 2] == IoRegionSel);
  assign wr_stall = IoBpEn && io_hit && ram.io_full;
  assign wr_byte  = wdata_q[8*cnt_q[1:0] +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      addr_q   <= '0;
      wdata_q  <= ZeroWord;
      lane_q   <= ZeroWord;
      src_if_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      lane_q   <= lane_d;
      src_if_q <= src_if_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    lane_d   = lane_q;
    src_if_d = src_if_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A stalled MEM stage blocks the whole pipeline, so it wins arbitration.
        if (req.mem_req) begin
          src_if_d = 1'b0;
          addr_d   = req.mem_addr;
          wdata_d  = req.mem_wdata;
          n_d      = sel_bytes(req.mem_sel);
          lane_d   = ZeroWord;
          if (mem_sel_e'(req.mem_sel) == MEM_NOP) state_d = DONE;
          else                                    state_d = req.mem_we ? MEM_WR : MEM_RD;
        end else if (req.if_req) begin
          src_if_d = 1'b1;
          addr_d   = req.if_addr;
          n_d      = 3'd4;
          lane_d   = ZeroWord;
          state_d  = IF_RD;
        end
      end
      IF_RD, MEM_RD: begin
        // RAM read data lags its address by one cycle: byte k lands in cycle k+1.
        case (cnt_q)
          3'd1:    lane_d[7:0]   = ram.ram_din;
          3'd2:    lane_d[15:8]  = ram.ram_din;
          3'd3:    lane_d[23:16] = ram.ram_din;
          3'd4:    lane_d[31:24] = ram.ram_din;
          default: ;
        endcase
        cnt_d = cnt_q + 3'd1;
        if (state_q == IF_RD && !req.if_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == n_q) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      MEM_WR: begin
        if (!wr_stall) begin
          if (cnt_q == n_q - 3'd1) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram.ram_a     = '0;
    ram.ram_wr    = 1'b0;
    ram.ram_dout  = ZeroByte;
    req.if_done   = 1'b0;
    req.if_data   = ZeroWord;
    req.mem_done  = 1'b0;
    req.mem_rdata = ZeroWord;
    case (state_q)
      IF_RD, MEM_RD: begin
        if (cnt_q < n_q) ram.ram_a = cur_a;
      end
      MEM_WR: begin
        ram.ram_a    = cur_a;
        ram.ram_dout = wr_byte;
        ram.ram_wr   = !wr_stall;
      end
      DONE: begin
        if (src_if_q) begin
          req.if_done = 1'b1;
          req.if_data = lane_q;
        end else begin
          req.mem_done  = 1'b1;
          req.mem_rdata = lane_q;
        end
      end
      default: ;
    endcase
  end

endmodule
